// File: rtl/debug_frame_sender.sv
// Streams one captured snapshot of the pipeline debug buses as a 37-byte UART frame (header, payload, XOR).
// Latency: request in IDLE -> header start pulse next cycle; each tx_done -> next start pulse next cycle.
// Backpressure: one byte in flight; the next byte waits for i_tx_done, and requests are ignored while busy.
module debug_frame_sender #(
    parameter int                 NB_DATA    = 8,
    parameter int                 NB_ID_EX   = 144,
    parameter int                 NB_EX_MEM  = 32,
    parameter int                 NB_MEM_WB  = 40,
    parameter int                 NB_WB_ID   = 40,
    parameter int                 NB_CONTROL = 24,
    parameter logic [NB_DATA-1:0] HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_dump_req,
    input  logic [NB_ID_EX-1:0]   i_concatenated_data_ID_EX,
    input  logic [NB_EX_MEM-1:0]  i_concatenated_data_EX_MEM,
    input  logic [NB_MEM_WB-1:0]  i_concatenated_data_MEM_WB,
    input  logic [NB_WB_ID-1:0]   i_concatenated_data_WB_ID,
    input  logic [NB_CONTROL-1:0] i_concatenated_data_CONTROL,
    input  logic                  i_tx_done,
    output logic                  o_tx_start,
    output logic [NB_DATA-1:0]    o_data,
    output logic                  o_busy,
    output logic                  o_dump_done
);

    localparam int NB_PAYLOAD = NB_ID_EX + NB_EX_MEM + NB_MEM_WB + NB_WB_ID + NB_CONTROL;
    localparam int N_PAY      = NB_PAYLOAD / NB_DATA;
    localparam logic [5:0] LAST_IDX = 6'(N_PAY + 1);

    typedef struct packed {
        logic [NB_ID_EX-1:0]   id_ex;
        logic [NB_EX_MEM-1:0]  ex_mem;
        logic [NB_MEM_WB-1:0]  mem_wb;
        logic [NB_WB_ID-1:0]   wb_id;
        logic [NB_CONTROL-1:0] control;
    } snap_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         index_q, index_d;
    logic [NB_DATA-1:0] csum_q, csum_d;
    snap_t              snap_q, snap_d;

    int                 pay_idx;
    logic [NB_DATA-1:0] payload_byte;
    logic [NB_DATA-1:0] frame_byte;

    // Frame index 1..N_PAY maps to payload bytes, most significant byte first.
    always_comb begin
        pay_idx = 0;
        if (index_q != 6'd0 && index_q != LAST_IDX) begin
            pay_idx = int'(index_q) - 1;
        end
        payload_byte = NB_DATA'(snap_q >> (NB_DATA * (N_PAY - 1 - pay_idx)));
        if (index_q == 6'd0) begin
            frame_byte = HEADER;
        end else if (index_q == LAST_IDX) begin
            frame_byte = csum_q;
        end else begin
            frame_byte = payload_byte;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        csum_d      = csum_q;
        snap_d      = snap_q;
        o_tx_start  = 1'b0;
        o_busy      = (state_q != ST_IDLE);
        o_dump_done = 1'b0;
        o_data      = (state_q == ST_IDLE) ? '0 : frame_byte;
        unique case (state_q)
            ST_IDLE: begin
                if (i_dump_req) begin
                    snap_d  = '{id_ex:   i_concatenated_data_ID_EX,
                                ex_mem:  i_concatenated_data_EX_MEM,
                                mem_wb:  i_concatenated_data_MEM_WB,
                                wb_id:   i_concatenated_data_WB_ID,
                                control: i_concatenated_data_CONTROL};
                    index_d = '0;
                    csum_d  = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                o_tx_start = 1'b1;
                if (index_q != 6'd0 && index_q != LAST_IDX) begin
                    csum_d = csum_q ^ payload_byte;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (index_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 6'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                o_dump_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            csum_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            csum_q  <= csum_d;
            snap_q  <= snap_d;
        end
    end

endmodule

// File: tb/tb_debug_frame_sender.sv
// Bench for debug_frame_sender: a uart_tx responder, a byte/timing monitor and a frame model built from the bus values.
module tb_debug_frame_sender;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_dump_req = 1'b0;
    logic [143:0] bus_id_ex = '0;
    logic [31:0]  bus_ex_mem = '0;
    logic [39:0]  bus_mem_wb = '0;
    logic [39:0]  bus_wb_id = '0;
    logic [23:0]  bus_ctrl = '0;
    logic         uart_done = 1'b0;
    logic         extra_done = 1'b0;
    logic         i_tx_done;
    logic         o_tx_start;
    logic [7:0]   o_data;
    logic         o_busy;
    logic         o_dump_done;

    assign i_tx_done = uart_done | extra_done;

    debug_frame_sender dut (
        .clk                         (clk),
        .i_rst                       (i_rst),
        .i_dump_req                  (i_dump_req),
        .i_concatenated_data_ID_EX   (bus_id_ex),
        .i_concatenated_data_EX_MEM  (bus_ex_mem),
        .i_concatenated_data_MEM_WB  (bus_mem_wb),
        .i_concatenated_data_WB_ID   (bus_wb_id),
        .i_concatenated_data_CONTROL (bus_ctrl),
        .i_tx_done                   (i_tx_done),
        .o_tx_start                  (o_tx_start),
        .o_data                      (o_data),
        .o_busy                      (o_busy),
        .o_dump_done                 (o_dump_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] got_q[$];
    int         start_cyc_q[$];
    int         dump_cyc_q[$];
    logic [7:0] exp_q[$];
    int         proto_err = 0;
    bit         prev_start = 1'b0;
    int         last_ud = 0;
    bit         last_ud_vld = 1'b0;
    int         cnt = 0;
    int         uart_delay = 10;
    bit         rand_delay = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor (records bytes, pulse spacing, done->start timing) followed by the uart_tx responder.
    always @(negedge clk) begin
        if (o_tx_start) begin
            got_q.push_back(o_data);
            start_cyc_q.push_back(cyc);
            if (prev_start) proto_err++;
            if (last_ud_vld && cyc != last_ud + 1) proto_err++;
            last_ud_vld = 1'b0;
        end
        if (o_dump_done) begin
            dump_cyc_q.push_back(cyc);
            if (!o_busy) proto_err++;
            if (!last_ud_vld || cyc != last_ud + 1) proto_err++;
            last_ud_vld = 1'b0;
        end
        prev_start = o_tx_start;
        uart_done = 1'b0;
        if (!o_busy) begin
            cnt = 0;
            last_ud_vld = 1'b0;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                uart_done = 1'b1;
                last_ud = cyc;
                last_ud_vld = 1'b1;
            end
        end
        if (o_tx_start) cnt = rand_delay ? int'($urandom_range(1, 12)) : uart_delay;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_buses_rand();
        bus_id_ex  = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
        bus_ex_mem = $urandom();
        bus_mem_wb = {$urandom(), 8'($urandom())};
        bus_wb_id  = {$urandom(), 8'($urandom())};
        bus_ctrl   = 24'($urandom());
    endtask

    task automatic set_buses_zero();
        bus_id_ex = '0; bus_ex_mem = '0; bus_mem_wb = '0; bus_wb_id = '0; bus_ctrl = '0;
    endtask

    // Reference frame: header, 35 payload bytes MSB first, then XOR of the payload bytes.
    task automatic build_exp();
        logic [279:0] p;
        logic [7:0]   b;
        logic [7:0]   chk;
        p = {bus_id_ex, bus_ex_mem, bus_mem_wb, bus_wb_id, bus_ctrl};
        chk = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 35; k++) begin
            b = p[279 - 8*k -: 8];
            exp_q.push_back(b);
            chk = chk ^ b;
        end
        exp_q.push_back(chk);
    endtask

    task automatic wait_dump(input int target, output bit ok);
        int n = 0;
        while (dump_cyc_q.size() < target && n < 1500) begin
            tick();
            n++;
        end
        ok = (dump_cyc_q.size() >= target);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_tx_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", o_tx_start); end
        checks++;
        if (o_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%02h exp=00", o_data); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++;
        if (o_dump_done !== 1'b0) begin failures++; $display("FAIL reset_dump_done got=%b exp=0", o_dump_done); end
        i_rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_zero_frame();
        int bb = got_q.size();
        int bd = dump_cyc_q.size();
        int be = proto_err;
        int bad;
        bit ok;
        rand_delay = 1'b0;
        uart_delay = 10;
        set_buses_zero();
        i_dump_req = 1'b1;
        build_exp();
        tick();
        i_dump_req = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_tx_start !== 1'b1 || o_data !== 8'hA5) begin
            failures++;
            $display("FAIL zero_first busy=%b start=%b data=%02h exp 1 1 a5", o_busy, o_tx_start, o_data);
        end
        wait_dump(bd + 1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL zero_timeout dumps=%0d exp=%0d", dump_cyc_q.size() - bd, 1); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after got=%b exp=0", o_busy); end
        repeat (4) tick();
        checks++;
        if (dump_cyc_q.size() - bd != 1) begin failures++; $display("FAIL zero_dump_count got=%0d exp=1", dump_cyc_q.size() - bd); end
        checks++;
        if (proto_err != be) begin failures++; $display("FAIL zero_protocol errors=%0d exp=0", proto_err - be); end
        checks++;
        if (got_q.size() - bb != 37) begin
            failures++; $display("FAIL zero_count got=%0d exp=37", got_q.size() - bb);
        end else begin
            bad = -1;
            for (int k = 36; k >= 0; k--) if (got_q[bb+k] !== exp_q[k]) bad = k;
            checks++;
            if (bad >= 0) begin failures++; $display("FAIL zero_bytes idx=%0d got=%02h exp=%02h", bad, got_q[bb+bad], exp_q[bad]); end
        end
    endtask

    task automatic test_exmem_pattern();
        int bb = got_q.size();
        int bd = dump_cyc_q.size();
        int bad;
        bit ok;
        rand_delay = 1'b1;
        set_buses_zero();
        bus_ex_mem = 32'h12345678;
        i_dump_req = 1'b1;
        build_exp();
        tick();
        i_dump_req = 1'b0;
        wait_dump(bd + 1, ok);
        checks++;
        if (!ok || got_q.size() - bb != 37) begin
            failures++; $display("FAIL exmem_count got=%0d exp=37", got_q.size() - bb);
        end else begin
            checks++;
            if (got_q[bb+19] !== 8'h12 || got_q[bb+20] !== 8'h34 || got_q[bb+21] !== 8'h56 ||
                got_q[bb+22] !== 8'h78 || got_q[bb+36] !== 8'h08) begin
                failures++;
                $display("FAIL exmem_bytes got=%02h %02h %02h %02h chk=%02h exp=12 34 56 78 chk=08",
                         got_q[bb+19], got_q[bb+20], got_q[bb+21], got_q[bb+22], got_q[bb+36]);
            end
            bad = -1;
            for (int k = 36; k >= 0; k--) if (got_q[bb+k] !== exp_q[k]) bad = k;
            checks++;
            if (bad >= 0) begin failures++; $display("FAIL exmem_frame idx=%0d got=%02h exp=%02h", bad, got_q[bb+bad], exp_q[bad]); end
        end
    endtask

    task automatic test_random_toggle();
        for (int it = 0; it < 3; it++) begin
            int bb = got_q.size();
            int bd = dump_cyc_q.size();
            int be = proto_err;
            int n = 0;
            int bad;
            rand_delay = 1'b1;
            set_buses_rand();
            i_dump_req = 1'b1;
            build_exp();
            tick();
            i_dump_req = 1'b0;
            while (dump_cyc_q.size() == bd && n < 1500) begin
                set_buses_rand();
                tick();
                n++;
            end
            tick();
            checks++;
            if (got_q.size() - bb != 37 || dump_cyc_q.size() - bd != 1) begin
                failures++;
                $display("FAIL toggle_count iter=%0d bytes=%0d dumps=%0d exp=37 1", it, got_q.size() - bb, dump_cyc_q.size() - bd);
            end else begin
                bad = -1;
                for (int k = 36; k >= 0; k--) if (got_q[bb+k] !== exp_q[k]) bad = k;
                checks++;
                if (bad >= 0) begin failures++; $display("FAIL toggle_bytes iter=%0d idx=%0d got=%02h exp=%02h", it, bad, got_q[bb+bad], exp_q[bad]); end
            end
            checks++;
            if (proto_err != be) begin failures++; $display("FAIL toggle_protocol iter=%0d errors=%0d exp=0", it, proto_err - be); end
        end
    endtask

    task automatic test_req_held();
        int bb = got_q.size();
        int bd = dump_cyc_q.size();
        int bad;
        bit ok;
        rand_delay = 1'b1;
        set_buses_rand();
        i_dump_req = 1'b1;
        build_exp();
        tick();
        wait_dump(bd + 1, ok);
        checks++;
        if (!ok || got_q.size() - bb != 37 || o_busy !== 1'b0) begin
            failures++; $display("FAIL held_first bytes=%0d busy=%b exp=37 0", got_q.size() - bb, o_busy);
        end
        tick();
        checks++;
        if (o_tx_start !== 1'b1 || o_data !== 8'hA5) begin
            failures++; $display("FAIL held_restart start=%b data=%02h exp=1 a5", o_tx_start, o_data);
        end
        i_dump_req = 1'b0;
        wait_dump(bd + 2, ok);
        repeat (5) tick();
        checks++;
        if (!ok || got_q.size() - bb != 74 || dump_cyc_q.size() - bd != 2) begin
            failures++;
            $display("FAIL held_count bytes=%0d dumps=%0d exp=74 2", got_q.size() - bb, dump_cyc_q.size() - bd);
        end else begin
            checks++;
            if (start_cyc_q[bb+37] != dump_cyc_q[bd] + 2) begin
                failures++; $display("FAIL held_gap got=%0d exp=2", start_cyc_q[bb+37] - dump_cyc_q[bd]);
            end
            bad = -1;
            for (int k = 73; k >= 0; k--) if (got_q[bb+k] !== exp_q[k % 37]) bad = k;
            checks++;
            if (bad >= 0) begin failures++; $display("FAIL held_bytes idx=%0d got=%02h exp=%02h", bad, got_q[bb+bad], exp_q[bad % 37]); end
        end
    endtask

    task automatic test_spurious_done();
        int bb = got_q.size();
        int bd = dump_cyc_q.size();
        int be = proto_err;
        int n = 0;
        int bad;
        rand_delay = 1'b1;
        extra_done = 1'b1;
        tick();
        extra_done = 1'b0;
        repeat (4) tick();
        checks++;
        if (got_q.size() != bb || o_busy !== 1'b0) begin
            failures++; $display("FAIL idle_stray bytes=%0d busy=%b exp=0 0", got_q.size() - bb, o_busy);
        end
        set_buses_rand();
        i_dump_req = 1'b1;
        build_exp();
        tick();
        i_dump_req = 1'b0;
        while (dump_cyc_q.size() == bd && n < 1500) begin
            extra_done = o_tx_start;
            tick();
            n++;
        end
        extra_done = 1'b0;
        tick();
        extra_done = 1'b1;
        tick();
        extra_done = 1'b0;
        repeat (4) tick();
        checks++;
        if (got_q.size() - bb != 37 || dump_cyc_q.size() - bd != 1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL spurious_count bytes=%0d dumps=%0d busy=%b exp=37 1 0", got_q.size() - bb, dump_cyc_q.size() - bd, o_busy);
        end else begin
            bad = -1;
            for (int k = 36; k >= 0; k--) if (got_q[bb+k] !== exp_q[k]) bad = k;
            checks++;
            if (bad >= 0) begin failures++; $display("FAIL spurious_bytes idx=%0d got=%02h exp=%02h", bad, got_q[bb+bad], exp_q[bad]); end
        end
        checks++;
        if (proto_err != be) begin failures++; $display("FAIL spurious_protocol errors=%0d exp=0", proto_err - be); end
    endtask

    task automatic test_reset_mid_frame();
        int bb = got_q.size();
        int bd = dump_cyc_q.size();
        int n = 0;
        int bad;
        bit ok;
        rand_delay = 1'b0;
        uart_delay = 3;
        set_buses_rand();
        i_dump_req = 1'b1;
        tick();
        i_dump_req = 1'b0;
        while (got_q.size() - bb < 11 && n < 500) begin
            tick();
            n++;
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if (o_tx_start !== 1'b0 || o_data !== 8'h00 || o_busy !== 1'b0 || o_dump_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs start=%b data=%02h busy=%b done=%b exp=0 00 0 0", o_tx_start, o_data, o_busy, o_dump_done);
        end
        repeat (20) tick();
        checks++;
        if (got_q.size() - bb != 11 || dump_cyc_q.size() != bd) begin
            failures++;
            $display("FAIL midrst_abort bytes=%0d dumps=%0d exp=11 0", got_q.size() - bb, dump_cyc_q.size() - bd);
        end
        bb = got_q.size();
        set_buses_rand();
        i_dump_req = 1'b1;
        build_exp();
        tick();
        i_dump_req = 1'b0;
        wait_dump(bd + 1, ok);
        checks++;
        if (!ok || got_q.size() - bb != 37) begin
            failures++; $display("FAIL midrst_count got=%0d exp=37", got_q.size() - bb);
        end else begin
            bad = -1;
            for (int k = 36; k >= 0; k--) if (got_q[bb+k] !== exp_q[k]) bad = k;
            checks++;
            if (bad >= 0) begin failures++; $display("FAIL midrst_bytes idx=%0d got=%02h exp=%02h", bad, got_q[bb+bad], exp_q[bad]); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_exmem_pattern();
        test_random_toggle();
        test_req_held();
        test_spurious_done();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_frame_sender.md
# debug_frame_sender

Sequencer that owns the UART transmitter during debug readout. On request it takes one snapshot of the pipeline debug buses (ID_EX, EX_MEM, MEM_WB, WB_ID, CONTROL). It then streams that snapshot as a fixed 37-byte frame (header, 35 payload bytes, XOR checksum) through the `uart_tx` start/done handshake. It sits between `uart_interface` and `uart_tx` and replaces the ad-hoc byte muxing for register dumps.

## Interface
Parameters:
- `NB_DATA`, 8, UART byte width
- `NB_ID_EX`, 144, ID_EX snapshot width
- `NB_EX_MEM`, 32, EX_MEM snapshot width
- `NB_MEM_WB`, 40, MEM_WB snapshot width
- `NB_WB_ID`, 40, WB_ID snapshot width
- `NB_CONTROL`, 24, CONTROL snapshot width
- `HEADER`, 8'hA5, first byte of every frame

Ports:
- `clk`  in  1  system clock; single clock domain
- `i_rst`  in  1  synchronous, active-high reset
- `i_dump_req`  in  1  start a frame; sampled only in IDLE
- `i_concatenated_data_ID_EX`  in  NB_ID_EX  snapshot source
- `i_concatenated_data_EX_MEM`  in  NB_EX_MEM  snapshot source
- `i_concatenated_data_MEM_WB`  in  NB_MEM_WB  snapshot source
- `i_concatenated_data_WB_ID`  in  NB_WB_ID  snapshot source
- `i_concatenated_data_CONTROL`  in  NB_CONTROL  snapshot source
- `i_tx_done`  in  1  byte-complete pulse from `uart_tx`
- `o_tx_start`  out  1  one-cycle start pulse to `uart_tx`
- `o_data`  out  NB_DATA  byte to transmit
- `o_busy`  out  1  frame in progress
- `o_dump_done`  out  1  one-cycle pulse after the last byte completes

## Operation
- Payload is the concatenation {ID_EX, EX_MEM, MEM_WB, WB_ID, CONTROL}: 280 bits = 35 bytes, sent MSB byte first.
- Frame byte index:
  - 0: HEADER
  - 1–18: ID_EX
  - 19–22: EX_MEM
  - 23–27: MEM_WB
  - 28–32: WB_ID
  - 33–35: CONTROL
  - 36: checksum
- Checksum is the XOR of the 35 payload bytes. It excludes the header and is accumulated as bytes are issued.
- Payload width is a multiple of NB_DATA by construction. Byte count is derived from the parameters; 6-bit index counter.
- States:
  - IDLE: o_busy=0. If i_dump_req=1, capture all five buses into the snapshot register, clear index and checksum, go to SEND.
  - SEND: drive o_data = byte[index], assert o_tx_start for exactly one cycle, fold the payload byte into the checksum, go to WAIT.
  - WAIT: hold o_data stable. On i_tx_done=1: if index==36 go to DONE, else increment index and go to SEND.
  - DONE: o_dump_done=1 for one cycle, then go to IDLE.
- Source buses may change freely after the capture cycle; the frame reflects the capture-cycle values only.
- i_dump_req outside IDLE is ignored and not queued. This includes DONE.
- i_tx_done outside WAIT is ignored. This includes the SEND cycle itself.
- Reset mid-frame aborts the frame: no further bytes are issued and the next request sends a complete new frame.

## Timing
- Reset values: o_tx_start=0, o_data=8'h00, o_busy=0, o_dump_done=0, state=IDLE, index=0, checksum=0, snapshot=0.
- Request at cycle N (IDLE) → o_busy=1 and o_tx_start=1 with o_data=HEADER at N+1.
- i_tx_done at cycle M (WAIT) → next o_tx_start at M+1, except after byte 36.
- Minimum spacing between start pulses is 2 cycles; actual spacing is set by UART bit timing.
- i_tx_done for byte 36 at cycle M:
  - o_dump_done=1 at M+1, with o_busy still 1.
  - o_busy=0 at M+2.
  - Earliest next accepted request is at M+2.
- o_tx_start is never high for two consecutive cycles. Exactly 37 start pulses per frame.

## Test plan
- All five buses zero, one request, `uart_tx` model returning done 10 cycles after each start → 37 bytes: A5, 35×00, 00; exactly one o_dump_done; o_busy low 2 cycles after the last done.
- ID_EX=0, EX_MEM=32'h12345678, others zero → bytes 19–22 = 12,34,56,78; checksum byte = 08.
- Sources toggled to random values every cycle after the capture cycle → frame matches the capture-cycle values exactly.
- i_dump_req held high for the whole frame and through DONE → one frame only; second frame starts at M+2 if still high.
- Spurious i_tx_done in the SEND cycle and a stray done in IDLE → no extra byte, no index skip, no start pulse.
- i_rst pulsed after byte 10 → outputs at reset values next cycle; new request yields a complete 37-byte frame with correct checksum.
